// File: rtl/entrada_operandos.sv
// entrada_operandos: debounced keypad sequencer for "digit + digit =".
// It drives operands A/B and the agora enable of the BCD adder.
module entrada_operandos #(
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tecla_press,
  input  logic [3:0] tecla_cod,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic       agora,
  output logic [2:0] estado,
  output logic       erro
);
  typedef enum logic [2:0] {
    ESP_A     = 3'd0,
    ESP_OP    = 3'd1,
    ESP_B     = 3'd2,
    ESP_IGUAL = 3'd3,
    MOSTRA    = 3'd4
  } estado_t;

  logic       sync1_q, press_s_q;
  logic [3:0] cod_s_q, cod_prev_q;
  logic [3:0] cnt_q, cnt_d;
  logic       disparado_q, disparado_d;
  logic       aceita;
  estado_t    st_q, st_d;
  logic [3:0] a_q, a_d, b_q, b_d;
  logic       erro_q, erro_d, agora_q, agora_d;

  // The counter saturates so a very long hold can never wrap back onto DEBOUNCE.
  always_comb begin
    cnt_d       = (press_s_q && cod_s_q == cod_prev_q) ? ((cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1) : 4'd0;
    aceita      = press_s_q && cnt_q == 4'(DEBOUNCE) && !disparado_q;
    disparado_d = press_s_q && (disparado_q || aceita);
  end

  always_comb begin
    st_d   = st_q;
    a_d    = a_q;
    b_d    = b_q;
    erro_d = erro_q;
    if (aceita) begin
      if (cod_s_q <= 4'd9) begin
        erro_d = 1'b0;
        case (st_q)
          ESP_A, ESP_OP: begin
            a_d  = cod_s_q;
            st_d = ESP_OP;
          end
          ESP_B, ESP_IGUAL: begin
            b_d  = cod_s_q;
            st_d = ESP_IGUAL;
          end
          MOSTRA: begin
            a_d  = cod_s_q;
            b_d  = 4'd0;
            st_d = ESP_OP;
          end
          default: st_d = ESP_A;
        endcase
      end else if (cod_s_q == 4'hA) begin
        st_d   = (st_q == ESP_OP) ? ESP_B : st_q;
        erro_d = st_q != ESP_OP;
      end else if (cod_s_q == 4'hB) begin
        st_d   = (st_q == ESP_IGUAL) ? MOSTRA : st_q;
        erro_d = st_q != ESP_IGUAL;
      end else if (cod_s_q == 4'hC) begin
        st_d   = ESP_A;
        a_d    = 4'd0;
        b_d    = 4'd0;
        erro_d = 1'b0;
      end
    end
    agora_d = st_d == MOSTRA;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      press_s_q   <= 1'b0;
      cod_s_q     <= 4'd0;
      cod_prev_q  <= 4'd0;
      cnt_q       <= 4'd0;
      disparado_q <= 1'b0;
      st_q        <= ESP_A;
      a_q         <= 4'd0;
      b_q         <= 4'd0;
      erro_q      <= 1'b0;
      agora_q     <= 1'b0;
    end else begin
      sync1_q     <= tecla_press;
      press_s_q   <= sync1_q;
      cod_s_q     <= tecla_cod;
      cod_prev_q  <= cod_s_q;
      cnt_q       <= cnt_d;
      disparado_q <= disparado_d;
      st_q        <= st_d;
      a_q         <= a_d;
      b_q         <= b_d;
      erro_q      <= erro_d;
      agora_q     <= agora_d;
    end
  end

  assign A      = a_q;
  assign B      = b_q;
  assign agora  = agora_q;
  assign estado = st_q;
  assign erro   = erro_q;
endmodule

// File: doc/entrada_operandos.md
# entrada_operandos

Keypad entry sequencer for the BCD calculator datapath. It debounces raw keypad presses and walks the entry sequence "digit, '+', digit, '='". It drives the single-digit operands `A` and `B` and the `agora` enable of the downstream 4-bit BCD adder stage. The adder is purely combinational and only drives its sum while `agora` is high, so this block owns all entry-side timing.

## Interface
Parameters:
- `DEBOUNCE`, default 4: consecutive cycles a synchronized press with unchanged code must persist before the key is accepted; legal range 1–15.

Ports:
- `clk` in 1: single clock; all state on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `tecla_press` in 1: raw asynchronous keypad level, high while a key is held.
- `tecla_cod` in 4: key code, valid while `tecla_press` is high.
  - 0–9: digits.
  - 4'hA: '+'.
  - 4'hB: '='.
  - 4'hC: clear.
  - 4'hD–4'hF: ignored.
- `A` out 4: operand A, BCD 0–9, registered.
- `B` out 4: operand B, BCD 0–9, registered.
- `agora` out 1: level; high while a complete A+B is presented to the adder.
- `estado` out 3: current FSM state encoding, for display/debug.
- `erro` out 1: high after an out-of-sequence key; registered.

## Operation
**Input path**
- `tecla_press` passes through a 2-flop synchronizer to form `press_s`.
- `tecla_cod` is registered alongside the second synchronizer stage to form `cod_s`.

**Debounce**
- A 4-bit counter increments each cycle `press_s`=1 and `cod_s` equals its previous value.
- The counter clears when `press_s`=0 or `cod_s` changes.
- When the counter reaches `DEBOUNCE` and flag `disparado`=0:
  - a one-cycle internal pulse `aceita` fires;
  - `disparado` is set.
- `disparado` clears only when `press_s`=0. Each physical press is therefore accepted exactly once, however long it is held.

**FSM states** (encoding in parentheses)
- ESP_A (0): waiting for first digit.
- ESP_OP (1): A held, waiting for '+'.
- ESP_B (2): waiting for second digit.
- ESP_IGUAL (3): B held, waiting for '='.
- MOSTRA (4): result shown, `agora`=1.

**Transitions** (on `aceita` only)
- Digit d:
  - ESP_A → A=d, go ESP_OP.
  - ESP_OP → A=d (overwrite), stay.
  - ESP_B → B=d, go ESP_IGUAL.
  - ESP_IGUAL → B=d (overwrite), stay.
  - MOSTRA → A=d, B=0, go ESP_OP.
- '+':
  - ESP_OP → ESP_B.
  - Any other state → error.
- '=':
  - ESP_IGUAL → MOSTRA.
  - Any other state → error.
- Clear (4'hC), from any state: A=0, B=0, `erro`=0, go ESP_A.
- Codes D–F: no state change, no error, `erro` unchanged.

**Error rule**
- An error sets `erro`=1 and leaves the state, A and B unchanged.
- Any later accepted digit, '+', '=' or clear that is legal in the current state clears `erro`.

**Output rules**
- `agora`=1 exactly when the state is MOSTRA.
- A and B never take values above 9.

## Timing
- Reset values:
  - `A`=0, `B`=0, `agora`=0, `erro`=0, `estado`=0 (ESP_A).
  - Synchronizer flops, `cod_s`, counter and `disparado` all 0.
- Latency: with `tecla_cod` stable, the state, A/B, `agora` and `erro` update on the (3+`DEBOUNCE`)th rising edge after the first edge that samples `tecla_press` high. This is 7 edges at the default.
- A code change while a key is held restarts the count from the changed cycle.
- A press shorter than `DEBOUNCE` synchronized cycles is discarded with no effect.
- A press of any length beyond the debounce window produces exactly one `aceita`.
- Release-and-re-press:
  - Re-arming requires at least one cycle with `press_s`=0.
  - The next acceptance then follows the full latency again.
- `agora` rises on the same edge the state enters MOSTRA. It falls on the same edge a digit or clear leaves MOSTRA.
- Reset mid-operation: all registers return to their reset values immediately. A key still held after `rst_n` rises is treated as a new press and accepted once after the full latency.

## Test plan
- Reset, then accept keys 3, '+', 5, '=' (each held 10 cycles, released 5) → A=3, B=5, `agora` rises 7 edges after '=' is sampled, `estado`=4, `erro`=0.
- Hold key 7 for 200 cycles in ESP_A → exactly one acceptance; A=7, `estado`=1; no further change while held.
- Glitch: `tecla_press` high for 3 cycles with `DEBOUNCE`=4 → no change. Code toggles 2→4 mid-hold → only 4 accepted, after a full count from the change.
- From ESP_A press '=' → `erro`=1, `estado`=0. Then digit 9 → A=9, `estado`=1, `erro`=0. From MOSTRA press 2 → A=2, B=0, `agora`=0, `estado`=1.
- Mid-sequence (A=4, ESP_B) press clear → A=0, B=0, `estado`=0. Assert `rst_n`=0 while in MOSTRA → all outputs 0 asynchronously, before the next clock edge.
